// File: rtl/sm3_cf_arbiter.sv
// Round-robin arbiter sharing one SM3 compression core between N_REQ clients; done/hash one cycle after cf_end.
// Optional RUN watchdog (err_o pulse on expiry) enabled by defining SM3_ARB_TIMEOUT_EN.
module sm3_cf_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N_REQ-1:0]     req_i,
  input  logic [N_REQ*256-1:0] req_iv_i,
  input  logic [N_REQ*512-1:0] req_blk_i,
  output logic [N_REQ-1:0]     gnt_o,
  output logic [N_REQ-1:0]     done_o,
  output logic [255:0]         hash_out_o,
  output logic                 busy_o,
  output logic                 cf_start_o,
  output logic [255:0]         cf_iv_o,
  output logic [511:0]         cf_blk_o,
  input  logic [255:0]         cf_hash_i,
`ifdef SM3_ARB_TIMEOUT_EN
  output logic [N_REQ-1:0]     err_o,
`endif
  input  logic                 cf_end_i
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [IW-1:0]    ptr_q, win_q;
  logic [N_REQ-1:0] gnt_q, done_q;
  logic [255:0]     hash_q, iv_q;
  logic [511:0]     blk_q;
  logic             start_q;

  logic [IW-1:0]    pick_d, ptr_nxt_d;
  logic             any_req_d;
  logic [255:0]     sel_iv_d;
  logic [511:0]     sel_blk_d;

`ifdef SM3_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [N_REQ-1:0] err_q;
  logic [7:0]       cnt_q;
`endif

  // Scan from the highest offset down so the offset nearest ptr_q overrides.
  always_comb begin
    logic [IW:0] j;
    pick_d    = ptr_q;
    any_req_d = 1'b0;
    j         = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = {1'b0, ptr_q} + (IW+1)'(k);
      if (j >= (IW+1)'(N_REQ)) j = j - (IW+1)'(N_REQ);
      if (req_i[j[IW-1:0]]) begin
        pick_d    = j[IW-1:0];
        any_req_d = 1'b1;
      end
    end
  end

  always_comb begin
    sel_iv_d  = '0;
    sel_blk_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_d == IW'(i)) begin
        sel_iv_d  = req_iv_i[256*i +: 256];
        sel_blk_d = req_blk_i[512*i +: 512];
      end
    end
  end

  assign ptr_nxt_d = (win_q == IW'(N_REQ - 1)) ? '0 : win_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      hash_q  <= '0;
      iv_q    <= '0;
      blk_q   <= '0;
      start_q <= 1'b0;
`ifdef SM3_ARB_TIMEOUT_EN
      err_q   <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req_d) begin
            win_q   <= pick_d;
            gnt_q   <= N_REQ'(1) << pick_d;
            iv_q    <= sel_iv_d;
            blk_q   <= sel_blk_d;
            start_q <= 1'b1;
            state_q <= RUN;
`ifdef SM3_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        RUN: begin
          if (cf_end_i) begin
            hash_q  <= cf_hash_i;
            done_q  <= N_REQ'(1) << win_q;
            start_q <= 1'b0;
            ptr_q   <= ptr_nxt_d;
            state_q <= DONE;
          end
`ifdef SM3_ARB_TIMEOUT_EN
          else if (cnt_q == TO_LAST) begin
            err_q   <= N_REQ'(1) << win_q;
            start_q <= 1'b0;
            ptr_q   <= ptr_nxt_d;
            state_q <= DONE;
          end else begin
            cnt_q   <= cnt_q + 8'd1;
          end
`endif
        end
        DONE: begin
          gnt_q   <= '0;
          done_q  <= '0;
`ifdef SM3_ARB_TIMEOUT_EN
          err_q   <= '0;
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o      = gnt_q;
  assign done_o     = done_q;
  assign hash_out_o = hash_q;
  assign busy_o     = (state_q != IDLE);
  assign cf_start_o = start_q;
  assign cf_iv_o    = iv_q;
  assign cf_blk_o   = blk_q;
`ifdef SM3_ARB_TIMEOUT_EN
  assign err_o      = err_q;
`endif

endmodule

// File: tb/tb_sm3_cf_arbiter.sv
// Scoreboard bench for sm3_cf_arbiter with a behavioural SM3 core model and round-robin reference.
// Define SM3_ARB_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES=16).
module tb_sm3_cf_arbiter;

  localparam int N = 4;
`ifdef SM3_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 255;
`endif

  localparam logic [255:0] SM3_IV  = 256'h7380166f4914b2b9172442d7da8a0600a96f30bc163138aae38dee4db0fb0e4e;
  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [255:0] ABC_H   = 256'h66c7f0f462eeedd9d1f2d46bdc10e4e24167c4875cf2f7a2297da02b8f4ba8e0;
  localparam logic [511:0] CH_BLK1 = {16{32'h61626364}};
  localparam logic [511:0] CH_BLK2 = {32'h80000000, 448'h0, 32'h00000200};
  localparam logic [255:0] CH_H    = 256'hdebe9ff92275b8a138604889c18e5a4d6fdb70e5387e5765293dcba39c0c5732;

  logic             clk, rst_n;
  logic [N-1:0]     req_i;
  logic [N*256-1:0] req_iv_i;
  logic [N*512-1:0] req_blk_i;
  logic [N-1:0]     gnt_o, done_o;
  logic [255:0]     hash_out_o, cf_iv_o, cf_hash_i;
  logic [511:0]     cf_blk_o;
  logic             busy_o, cf_start_o, cf_end_i;
`ifdef SM3_ARB_TIMEOUT_EN
  logic [N-1:0]     err_o;
`endif

  sm3_cf_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_i), .req_iv_i(req_iv_i), .req_blk_i(req_blk_i),
    .gnt_o(gnt_o), .done_o(done_o), .hash_out_o(hash_out_o), .busy_o(busy_o),
    .cf_start_o(cf_start_o), .cf_iv_o(cf_iv_o), .cf_blk_o(cf_blk_o), .cf_hash_i(cf_hash_i),
`ifdef SM3_ARB_TIMEOUT_EN
    .err_o(err_o),
`endif
    .cf_end_i(cf_end_i));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  logic core_mute = 1'b0;

  typedef struct { int cl; logic [255:0] h; } exp_t;
  exp_t sb[$];
  logic [255:0] cl_iv  [N];
  logic [511:0] cl_blk [N];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: bound expired or event not expected", name);
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    int s = n % 32;
    if (s == 0) return x;
    return (x << s) | (x >> (32 - s));
  endfunction

  function automatic logic [31:0] p0(input logic [31:0] x); return x ^ rotl(x, 9) ^ rotl(x, 17); endfunction
  function automatic logic [31:0] p1(input logic [31:0] x); return x ^ rotl(x, 15) ^ rotl(x, 23); endfunction

  function automatic logic [255:0] sm3_cf(input logic [255:0] v, input logic [511:0] b);
    logic [31:0] w [68];
    logic [31:0] wp [64];
    logic [31:0] a, bb, c, d, e, f, g, h, ss1, ss2, tt1, tt2, t, ff, gg;
    for (int j = 0; j < 16; j++) w[j] = b[511-32*j -: 32];
    for (int j = 16; j < 68; j++)
      w[j] = p1(w[j-16] ^ w[j-9] ^ rotl(w[j-3], 15)) ^ rotl(w[j-13], 7) ^ w[j-6];
    for (int j = 0; j < 64; j++) wp[j] = w[j] ^ w[j+4];
    {a, bb, c, d, e, f, g, h} = v;
    for (int j = 0; j < 64; j++) begin
      t   = (j < 16) ? 32'h79cc4519 : 32'h7a879d8a;
      ss1 = rotl(rotl(a, 12) + e + rotl(t, j), 7);
      ss2 = ss1 ^ rotl(a, 12);
      ff  = (j < 16) ? (a ^ bb ^ c) : ((a & bb) | (a & c) | (bb & c));
      gg  = (j < 16) ? (e ^ f ^ g) : ((e & f) | (~e & g));
      tt1 = ff + d + ss2 + wp[j];
      tt2 = gg + h + ss1 + w[j];
      d = c; c = rotl(bb, 9); bb = a; a = tt1;
      h = g; g = rotl(f, 19); f = e; e = p0(tt2);
    end
    return {a, bb, c, d, e, f, g, h} ^ v;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [511:0] rand512();
    return {rand256(), rand256()};
  endfunction

  // Round robin from the rules: first requester at or after ptr, wrapping.
  function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
    for (int k = 0; k < N; k++)
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // Core model: random latency, plus stray cf_end pulses the arbiter must ignore.
  initial begin : core_model
    int st, cnt;
    logic [255:0] civ;
    logic [511:0] cblk;
    cf_end_i = 1'b0; cf_hash_i = '0; st = 0; cnt = 0; civ = '0; cblk = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        st = 0; cf_end_i = 1'b0;
      end else begin
        case (st)
          0: begin
            if (cf_start_o && !core_mute) begin
              civ = cf_iv_o; cblk = cf_blk_o; cnt = $urandom_range(0, 5); st = 1;
            end else if (!cf_start_o && !core_mute && $urandom_range(0, 15) == 0) begin
              cf_end_i = 1'b1; cf_hash_i = rand256(); st = 3;
            end
          end
          1: begin
            if (cnt == 0) begin cf_end_i = 1'b1; cf_hash_i = sm3_cf(civ, cblk); st = 2; end
            else cnt--;
          end
          2: begin
            if ($urandom_range(0, 3) == 0) begin cf_hash_i = rand256(); st = 3; end
            else begin cf_end_i = 1'b0; st = 0; end
          end
          default: begin cf_end_i = 1'b0; cf_hash_i = rand256(); st = 0; end
        endcase
      end
    end
  end

  initial begin : monitor
    logic [N-1:0] prev_gnt, prev_fin, last_req, fin;
    logic [255:0] last_hash;
    int model_ptr, w, job_len;
    exp_t e;
    prev_gnt = '0; prev_fin = '0; last_req = '0; last_hash = '0; model_ptr = 0; job_len = 0;
    forever begin
      @(negedge clk);
      fin = done_o;
`ifdef SM3_ARB_TIMEOUT_EN
      fin = fin | err_o;
`endif
      if (!rst_n) begin
        chk("reset_ctl", {gnt_o, done_o, busy_o, cf_start_o}, '0);
        chk("reset_hash", hash_out_o, '0);
        chk("reset_cf_iv", cf_iv_o, '0);
        chk("reset_cf_blk", cf_blk_o, '0);
        sb.delete();
        model_ptr = 0; prev_gnt = '0; prev_fin = '0; last_req = '0; last_hash = '0; job_len = 0;
      end else begin
        if (prev_fin != 0) begin
          chk("release", {gnt_o, busy_o, cf_start_o}, '0);
        end else if (prev_gnt == 0) begin
          if (last_req != 0) begin
            w = rr_pick(last_req, model_ptr);
            chk("grant", gnt_o, 512'(1) << w);
            chk("start_busy", {cf_start_o, busy_o}, 2'b11);
            chk("latch_iv", cf_iv_o, cl_iv[w]);
            chk("latch_blk", cf_blk_o, cl_blk[w]);
            sb.push_back('{w, sm3_cf(cl_iv[w], cl_blk[w])});
          end else begin
            chk("idle", {gnt_o, busy_o, cf_start_o}, '0);
          end
        end else begin
          chk("gnt_hold", gnt_o, prev_gnt);
          chk("start_level", cf_start_o, fin == 0);
        end
        if (fin != 0) begin
          if (sb.size() == 0) fail_now("unexpected_done");
          else begin
            e = sb.pop_front();
            if (done_o != 0) begin
              chk("done_dst", done_o, 512'(1) << e.cl);
              chk("digest", hash_out_o, e.h);
              last_hash = e.h;
            end
`ifdef SM3_ARB_TIMEOUT_EN
            else begin
              chk("err_dst", err_o, 512'(1) << e.cl);
              chk("err_hash_kept", hash_out_o, last_hash);
            end
`endif
            model_ptr = (e.cl + 1) % N;
          end
        end else begin
          chk("hash_hold", hash_out_o, last_hash);
        end
        job_len = (gnt_o != 0) ? job_len + 1 : 0;
        if (job_len == 100) fail_now("job_stuck");
        prev_gnt = gnt_o;
        prev_fin = fin;
        last_req = req_i;
      end
    end
  end

  task automatic raise(input int c, input logic [255:0] iv, input logic [511:0] blk);
    cl_iv[c] = iv;
    cl_blk[c] = blk;
    req_iv_i[256*c +: 256] = iv;
    req_blk_i[512*c +: 512] = blk;
    req_i[c] = 1'b1;
  endtask

  task automatic wait_done(input int c, output logic [255:0] h);
    int cyc = 0;
    h = '0;
    while (cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      if (done_o[c]) begin h = hash_out_o; req_i[c] = 1'b0; break; end
    end
    if (cyc >= 300) begin fail_now("wait_done"); req_i[c] = 1'b0; end
  endtask

  task automatic serve(input logic [N-1:0] mask, output int first, output int second);
    int cyc = 0, got = 0;
    first = -1; second = -1;
    for (int i = 0; i < N; i++) if (mask[i]) raise(i, rand256(), rand512());
    while (got < 2 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      for (int i = 0; i < N; i++)
        if (req_i[i] && done_o[i]) begin
          req_i[i] = 1'b0;
          if (got == 0) first = i; else second = i;
          got++;
        end
    end
    if (got < 2) fail_now("serve");
    req_i = '0;
  endtask

  task automatic drain();
    int cyc = 0;
    req_i = '0;
    while (busy_o && cyc < 300) begin @(posedge clk); #1; cyc++; end
    if (busy_o) fail_now("drain");
    repeat (3) @(posedge clk);
    #1;
  endtask

  int a0, a1;
  logic [255:0] h1, h2;
  int flog[$];
  int cool [N];
  int left [N];
  logic active [N];
  logic [255:0] dig [N];
  logic have_dig;

  initial begin : main
    rst_n = 1'b0; req_i = '0; req_iv_i = '0; req_blk_i = '0;
    for (int i = 0; i < N; i++) begin cl_iv[i] = '0; cl_blk[i] = '0; end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    serve(4'b1010, a0, a1);
    chk("contention_first", 32'(a0), 32'd1);
    chk("contention_second", 32'(a1), 32'd3);
    drain();

    raise(0, SM3_IV, ABC_BLK);
    wait_done(0, h1);
    chk("abc_digest", h1, ABC_H);
    drain();

    raise(2, SM3_IV, CH_BLK1);
    wait_done(2, h1);
    repeat (2) @(posedge clk);
    #1 raise(2, h1, CH_BLK2);
    wait_done(2, h2);
    chk("chain_digest", h2, CH_H);
    drain();

    raise(1, rand256(), rand512());
    a0 = 0;
    while (!cf_start_o && a0 < 50) begin @(posedge clk); #1; a0++; end
    if (!cf_start_o) fail_now("mid_run_start");
    rst_n = 1'b0;
    req_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_reset_outputs", {gnt_o, done_o, busy_o, cf_start_o}, '0);
    rst_n = 1'b1;
    serve(4'b1010, a0, a1);
    chk("post_reset_ptr0", 32'(a0), 32'd1);
    drain();

    for (int i = 0; i < N; i++) begin raise(i, rand256(), rand512()); cool[i] = 0; end
    a0 = 0;
    while (flog.size() < 12 && a0 < 800) begin
      @(posedge clk); #1;
      a0++;
      for (int i = 0; i < N; i++) begin
        if (req_i[i] && done_o[i]) begin
          req_i[i] = 1'b0; cool[i] = 2; flog.push_back(i);
        end else if (!req_i[i] && cool[i] > 0) begin
          cool[i]--;
          if (cool[i] == 0) raise(i, rand256(), rand512());
        end
      end
    end
    if (flog.size() < 12) fail_now("fairness_bound");
    for (int k = 0; k < flog.size(); k++) chk("fair_order", 32'(flog[k]), 32'(k % N));
    drain();

    have_dig = 1'b0;
    for (int i = 0; i < N; i++) begin cool[i] = $urandom_range(0, 3); left[i] = 12; active[i] = 1'b0; dig[i] = '0; end
    a0 = 0;
    while (a0 < 4000 && (left[0] + left[1] + left[2] + left[3] > 0 || active[0] || active[1] || active[2] || active[3])) begin
      @(posedge clk); #1;
      a0++;
      for (int i = 0; i < N; i++) begin
        if (active[i] && done_o[i]) begin
          active[i] = 1'b0; req_i[i] = 1'b0; cool[i] = $urandom_range(0, 3); dig[i] = hash_out_o;
          if (i == 2) have_dig = 1'b1;
        end else if (active[i] && req_i[i] && gnt_o[i] && $urandom_range(0, 7) == 0) begin
          req_i[i] = 1'b0;
          req_iv_i[256*i +: 256] = rand256();
          req_blk_i[512*i +: 512] = rand512();
        end else if (!active[i] && cool[i] == 0 && left[i] > 0) begin
          raise(i, (i == 2 && have_dig && $urandom_range(0, 1) == 1) ? dig[2] : rand256(), rand512());
          active[i] = 1'b1; left[i]--;
        end else if (!active[i] && cool[i] > 0) begin
          cool[i]--;
        end
      end
    end
    if (a0 >= 4000) fail_now("random_bound");
    drain();

`ifdef SM3_ARB_TIMEOUT_EN
    core_mute = 1'b1;
    repeat (3) @(posedge clk);
    #1 h1 = hash_out_o;
    raise(0, rand256(), rand512());
    a0 = 0;
    while (!gnt_o[0] && a0 < 20) begin @(posedge clk); #1; a0++; end
    a1 = 0;
    while (a1 < 40) begin
      @(posedge clk); #1;
      a1++;
      if (err_o[0]) break;
    end
    req_i = '0;
    chk("to_cycle", 32'(a1), 32'(TO));
    chk("to_no_done", done_o, '0);
    @(posedge clk); #1;
    chk("to_busy_low", busy_o, 1'b0);
    chk("to_hash_kept", hash_out_o, h1);
    core_mute = 1'b0;
    drain();
`endif

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
